// File: rtl/neg_unit_arbiter.sv
// neg_unit_arbiter: round-robin front end for a shared two's-complement unit.
// One operand at a time is granted, latched, negated in a dedicated cycle and
// returned with the owning requester index on a valid/ready response port.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for any request; grant goes combinationally to winner
// S_COMPUTE | latched operand is negated into the response registers
// S_RESP    | response presented, held stable until the consumer accepts
module neg_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*WIDTH-1:0]   i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [WIDTH-1:0]         o_rsp_data,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic                     o_rsp_ovf,
  output logic                     o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_winner;
  logic [WIDTH-1:0]  r_operand;
  logic [WIDTH-1:0]  r_rsp_data;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_ovf;

  logic [2*N_REQ-1:0] w_valid_dbl;
  logic [N_REQ-1:0]   w_valid_rot;
  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W:0]      w_sum;
  logic [WIDTH-1:0]   w_operand;
  logic               w_grant;
  logic               w_rsp_fire;
  logic [ID_W-1:0]    w_ptr_inc;

  // Rotate requests so bit 0 is the round-robin pointer, then take the first set bit.
  always_comb begin
    w_valid_dbl = {i_req_valid, i_req_valid} >> r_rr_ptr;
    w_valid_rot = w_valid_dbl[N_REQ-1:0];
    w_found     = 1'b0;
    w_winner    = '0;
    w_sum       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_valid_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
        if (w_sum >= (ID_W+1)'(N_REQ)) begin
          w_sum = w_sum - (ID_W+1)'(N_REQ);
        end
        w_winner = w_sum[ID_W-1:0];
      end
    end
  end

  // Select the winning requester's operand.
  always_comb begin
    w_operand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_winner == ID_W'(k)) begin
        w_operand = i_req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic, grant and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    w_grant     = 1'b0;
    w_rsp_fire  = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        // Grant is suppressed while reset is asserted.
        if (w_found && !i_rst) begin
          w_grant     = 1'b1;
          o_req_ready = N_REQ'(1) << w_winner;
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_ptr_inc = (r_winner == ID_W'(N_REQ-1)) ? '0 : r_winner + 1'b1;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, negation, response hold and pointer advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr   <= '0;
      r_winner   <= '0;
      r_operand  <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_rsp_ovf  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_operand <= w_operand;
        r_winner  <= w_winner;
      end
      if (r_state == S_COMPUTE) begin
        r_rsp_data <= ~r_operand + 1'b1;
        r_rsp_id   <= r_winner;
        r_rsp_ovf  <= (r_operand == MOST_NEG);
      end
      if (w_rsp_fire) begin
        r_rr_ptr <= w_ptr_inc;
      end
    end
  end

  assign o_rsp_data = r_rsp_data;
  assign o_rsp_id   = r_rsp_id;
  assign o_rsp_ovf  = r_rsp_ovf;

endmodule

// File: tb/tb_neg_unit_arbiter.sv
// Testbench for neg_unit_arbiter: directed steps plus random transactions,
// checked against a transaction-level reference model.
module tb_neg_unit_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;
  logic           rsp_ovf;
  logic           busy;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  neg_unit_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_id    (rsp_id),
    .o_rsp_ovf   (rsp_ovf),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first valid requester from the pointer, wrapping.
  function automatic int scan(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int w);
    return (w < 0) ? 32'd0 : (32'd1 << w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_data  = '1;
    rsp_ready = 1'b1;
    #1;
    chk("rst.ready_held", 32'(req_ready), 32'd0);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.busy",      32'(busy),      32'd0);
    chk("rst.rsp_data",  32'(rsp_data),  32'd0);
    chk("rst.rsp_id",    32'(rsp_id),    32'd0);
    chk("rst.rsp_ovf",   32'(rsp_ovf),   32'd0);
    m_ptr = 0;
  endtask

  // One complete transaction: grant, compute, response with optional stall.
  task automatic serve(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input int stall, input string tag);
    int w;
    int x;
    int exp_d;
    int exp_o;
    req_valid = v;
    req_data  = d;
    rsp_ready = 1'b0;
    #1;
    w = scan(v, m_ptr);
    if (w < 0) begin
      chk({tag, ".noreq_ready"}, 32'(req_ready), 32'd0);
      tick();
      chk({tag, ".noreq_busy"}, 32'(busy), 32'd0);
      return;
    end
    x     = int'((d >> (w * W)) & ((1 << W) - 1));
    exp_d = ((1 << W) - x) % (1 << W);
    exp_o = (x == (1 << (W - 1))) ? 1 : 0;
    chk({tag, ".grant"}, 32'(req_ready), onehot(w));
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    tick();
    chk({tag, ".cmp_ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".cmp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".cmp_busy"},  32'(busy),      32'd1);
    tick();
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_data"},  32'(rsp_data),  32'(exp_d));
    chk({tag, ".rsp_id"},    32'(rsp_id),    32'(w));
    chk({tag, ".rsp_ovf"},   32'(rsp_ovf),   32'(exp_o));
    chk({tag, ".rsp_ready"}, 32'(req_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({tag, ".stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".stall_data"},  32'(rsp_data),  32'(exp_d));
      chk({tag, ".stall_id"},    32'(rsp_id),    32'(w));
      chk({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    m_ptr = (w + 1) % N;
    chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".next_grant"}, 32'(req_ready), onehot(scan(v, m_ptr)));
  endtask

  initial begin
    logic [N-1:0]   rv;
    logic [N*W-1:0] rd;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    tick();

    // Single requester 2, operand 3; pointer then sits at 3.
    do_reset();
    serve(4'b0100, 16'h0300, 0, "t1");
    serve(4'b1111, 16'h1234, 0, "t1.ptr3");

    // Operand sweep through requester 0.
    for (int x = 0; x < 16; x++) begin
      serve(4'b0001, 16'(x), 0, "t2.sweep");
    end

    // All requesters continuously asking.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      serve(4'b1111, 16'h4321, 0, "t3.rr");
    end

    // Response backpressure with everyone waiting.
    serve(4'b1111, 16'h5555, 5, "t4.bp");

    // Reset during COMPUTE after the pointer has moved away from 0.
    do_reset();
    serve(4'b0010, 16'h0070, 0, "t5.pre");
    req_valid = 4'b0100;
    req_data  = 16'h0600;
    #1;
    chk("t5a.grant", 32'(req_ready), 32'h4);
    tick();
    chk("t5a.busy", 32'(busy), 32'd1);
    req_valid = '0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5a.valid", 32'(rsp_valid), 32'd0);
    chk("t5a.busy0", 32'(busy),      32'd0);
    chk("t5a.data0", 32'(rsp_data),  32'd0);
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5a.no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Reset during RESP, colliding with a response handshake.
    req_valid = 4'b1000;
    req_data  = 16'h3000;
    #1;
    chk("t5b.grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick();
    chk("t5b.valid1", 32'(rsp_valid), 32'd1);
    chk("t5b.data",   32'(rsp_data),  32'hd);
    rst       = 1'b1;
    rsp_ready = 1'b1;
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("t5b.valid", 32'(rsp_valid), 32'd0);
    chk("t5b.busy0", 32'(busy),      32'd0);
    chk("t5b.data0", 32'(rsp_data),  32'd0);
    chk("t5b.id0",   32'(rsp_id),    32'd0);
    m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5b.no_rsp", 32'(rsp_valid), 32'd0);
    end
    serve(4'b1111, 16'h9abc, 0, "t5.after");

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      rv = N'($urandom_range(0, (1 << N) - 1));
      rd = (N*W)'($urandom);
      serve(rv, rd, int'($urandom_range(0, 3)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
